// File: rtl/ser_pkg.sv
// Shared types and constants for the ser_gen serializer.
// SER_GEN_PARITY_EN adds one even-parity beat per word.
package ser_pkg;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StShift = 1'b1
  } ser_state_e;

`ifdef SER_GEN_PARITY_EN
  localparam int unsigned ParityBeat = 1;
`else
  localparam int unsigned ParityBeat = 0;
`endif

  // Beats needed to send one word, including the optional parity beat.
  function automatic int unsigned beats_per_word(int unsigned data_w, int unsigned lanes);
    return data_w / lanes + ParityBeat;
  endfunction

endpackage

// File: rtl/ser_hold_reg.sv
// Single-entry holding register in front of the serializer shift register.
// Ready stays low until one edge after reset has been released.
module ser_hold_reg #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              pop_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              full_o
);

  logic              full_q;
  logic              ready_en_q;
  logic [DATA_W-1:0] data_q;
  logic              push;

  assign in_ready_o = ready_en_q & ~full_q;
  assign push       = in_valid_i & in_ready_o;
  assign out_data_o = data_q;
  assign full_o     = full_q;

  // push requires an empty register and pop a full one, so they never coincide
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      full_q     <= 1'b0;
      ready_en_q <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
      if (push) begin
        full_q <= 1'b1;
      end else if (pop_i) begin
        full_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      data_q <= in_data_i;
    end
  end

endmodule

// File: rtl/ser_gen.sv
// Parallel-to-serial generator: LANES bits per beat, two-word buffering.
// Define SER_GEN_PARITY_EN to append an even-parity beat to every word.
module ser_gen
  import ser_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned LANES     = 1,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b0
) (
  input  logic              clock_160,
  input  logic              reset,
  input  logic              enable,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic [LANES-1:0]  data_out,
  output logic              frame_start,
  output logic              busy
);

  localparam int unsigned NSlices = DATA_W / LANES;
  localparam int unsigned Beats   = beats_per_word(DATA_W, LANES);
  localparam int unsigned CntW    = $clog2(Beats + 1);

  if ((DATA_W < 2) || (DATA_W > 64) || ((DATA_W % LANES) != 0)) begin : g_param_check
    $error("ser_gen: DATA_W must be 2..64 and divisible by LANES");
  end

  ser_state_e        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] sh_q, sh_d, sh_next;
  logic [LANES-1:0]  beat_data;
  logic [DATA_W-1:0] hold_data;
  logic              hold_full;
  logic              hold_pop;
  logic              last_beat;
  logic              load;

`ifdef SER_GEN_PARITY_EN
  logic par_q, par_d;
`endif

  ser_hold_reg #(
    .DATA_W(DATA_W)
  ) u_hold (
    .clk_i     (clock_160),
    .rst_ni    (reset),
    .in_data_i (data_in),
    .in_valid_i(data_valid),
    .in_ready_o(data_ready),
    .pop_i     (hold_pop),
    .out_data_o(hold_data),
    .full_o    (hold_full)
  );

  // The outgoing slice always sits at the leading end of the shift register.
  if (MSB_FIRST) begin : g_msb
    assign beat_data = sh_q[DATA_W-1 -: LANES];
    assign sh_next   = sh_q << LANES;
  end else begin : g_lsb
    assign beat_data = sh_q[LANES-1:0];
    assign sh_next   = sh_q >> LANES;
  end

  assign last_beat = (cnt_q == CntW'(Beats - 1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    hold_pop = 1'b0;
    load     = 1'b0;
`ifdef SER_GEN_PARITY_EN
    par_d    = par_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (enable && hold_full) begin
          load = 1'b1;
        end
      end
      StShift: begin
        if (enable) begin
          if (last_beat) begin
            cnt_d = '0;
            if (hold_full) begin
              load = 1'b1;
            end else begin
              state_d = StIdle;
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
            sh_d  = sh_next;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (load) begin
      state_d  = StShift;
      cnt_d    = '0;
      sh_d     = hold_data;
      hold_pop = 1'b1;
`ifdef SER_GEN_PARITY_EN
      par_d    = ^hold_data;
`endif
    end
  end

  always_ff @(posedge clock_160) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
    end
  end

`ifdef SER_GEN_PARITY_EN
  always_ff @(posedge clock_160) begin
    if (!reset) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`endif

  always_comb begin
    data_out = {LANES{IDLE_BIT}};
    if (state_q == StShift) begin
      data_out = beat_data;
`ifdef SER_GEN_PARITY_EN
      if (cnt_q == CntW'(NSlices)) begin
        data_out    = {LANES{IDLE_BIT}};
        data_out[0] = par_q;
      end
`endif
    end
  end

  assign frame_start = (state_q == StShift) && (cnt_q == '0) && enable;
  assign busy        = (state_q == StShift) || hold_full;

endmodule

// File: tb/tb_ser_gen.sv
// Self-checking bench for ser_gen: three configurations share one stimulus stream
// and are compared every cycle against a word/beat-level reference model.
module tb_ser_gen;

`ifdef SER_GEN_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic       clock_160;
  logic       reset;
  logic       enable;
  logic [7:0] data_in;
  logic       data_valid;

  logic       rdy0, rdy1, rdy2;
  logic [0:0] dout0;
  logic [1:0] dout1, dout2;
  logic       fs0, fs1, fs2;
  logic       busy0, busy1, busy2;

  int n_vec;
  int n_err;
  int fs_cnt;

  // Reference model state per instance: remaining beats of current word, held word.
  int unsigned m_left  [3];
  logic [7:0]  m_word  [3];
  bit          m_held  [3];
  logic [7:0]  m_hword [3];
  bit          m_rdy   [3];
  bit          m_acc0;

  ser_gen #(.DATA_W(8), .LANES(1), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_dut0 (
    .clock_160  (clock_160),
    .reset      (reset),
    .enable     (enable),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (rdy0),
    .data_out   (dout0),
    .frame_start(fs0),
    .busy       (busy0)
  );

  ser_gen #(.DATA_W(8), .LANES(2), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_dut1 (
    .clock_160  (clock_160),
    .reset      (reset),
    .enable     (enable),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (rdy1),
    .data_out   (dout1),
    .frame_start(fs1),
    .busy       (busy1)
  );

  ser_gen #(.DATA_W(8), .LANES(2), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_dut2 (
    .clock_160  (clock_160),
    .reset      (reset),
    .enable     (enable),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (rdy2),
    .data_out   (dout2),
    .frame_start(fs2),
    .busy       (busy2)
  );

  initial clock_160 = 1'b0;
  always #5 clock_160 = ~clock_160;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running required done");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int lanes_of(int c);
    return (c == 0) ? 1 : 2;
  endfunction

  function automatic int beats_of(int c);
    return 8 / lanes_of(c) + PAR;
  endfunction

  function automatic logic [1:0] idle_of(int c);
    return (c == 2) ? 2'b11 : 2'b00;
  endfunction

  // Beat idx of word w: slice order from MSB_FIRST, parity beat after the data slices.
  function automatic logic [1:0] beat_val(int c, logic [7:0] w, int idx);
    int         lanes;
    int         ns;
    int         s;
    logic [1:0] r;
    lanes = lanes_of(c);
    ns    = 8 / lanes;
    if (idx >= ns) begin
      r    = idle_of(c);
      r[0] = ^w;
      return r;
    end
    s = (c == 2) ? idx : ns - 1 - idx;
    return 2'((int'(w) >> (s * lanes)) & ((1 << lanes) - 1));
  endfunction

  task automatic model_update();
    bit acc;
    for (int c = 0; c < 3; c++) begin
      if (!reset) begin
        m_left[c] = 0;
        m_held[c] = 1'b0;
        m_rdy[c]  = 1'b0;
        acc       = 1'b0;
      end else begin
        acc = data_valid && m_rdy[c] && !m_held[c];
        if (enable) begin
          if (m_left[c] > 0) m_left[c]--;
          if (m_left[c] == 0 && m_held[c]) begin
            m_word[c] = m_hword[c];
            m_left[c] = beats_of(c);
            m_held[c] = 1'b0;
          end
        end
        if (acc) begin
          m_held[c]  = 1'b1;
          m_hword[c] = data_in;
        end
        m_rdy[c] = 1'b1;
      end
      if (c == 0) m_acc0 = acc;
    end
  endtask

  task automatic compare_all();
    logic [63:0] g_dout, g_fs, g_busy, g_rdy;
    logic [1:0]  e_dout;
    for (int c = 0; c < 3; c++) begin
      g_dout = (c == 0) ? 64'(dout0) : (c == 1) ? 64'(dout1) : 64'(dout2);
      g_fs   = (c == 0) ? 64'(fs0)   : (c == 1) ? 64'(fs1)   : 64'(fs2);
      g_busy = (c == 0) ? 64'(busy0) : (c == 1) ? 64'(busy1) : 64'(busy2);
      g_rdy  = (c == 0) ? 64'(rdy0)  : (c == 1) ? 64'(rdy1)  : 64'(rdy2);
      e_dout = (m_left[c] > 0) ? beat_val(c, m_word[c], beats_of(c) - int'(m_left[c]))
                               : idle_of(c);
      if (c == 0) e_dout[1] = 1'b0;
      check_eq($sformatf("data_out[%0d]", c), g_dout, 64'(e_dout));
      check_eq($sformatf("frame_start[%0d]", c), g_fs,
               64'(enable && (m_left[c] == beats_of(c))));
      check_eq($sformatf("busy[%0d]", c), g_busy, 64'((m_left[c] > 0) || m_held[c]));
      check_eq($sformatf("data_ready[%0d]", c), g_rdy, 64'(m_rdy[c] && !m_held[c]));
    end
  endtask

  task automatic step(input bit r, input bit e, input bit v, input logic [7:0] d);
    reset      = r;
    enable     = e;
    data_valid = v;
    data_in    = d;
    @(posedge clock_160);
    #1;
    model_update();
    compare_all();
    if (fs0) fs_cnt++;
  endtask

  task automatic drain();
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, 8'h00);
  endtask

  logic [1:0] obs0 [8];
  logic [1:0] obs1 [4];
  logic [1:0] obs2 [4];
  logic [1:0] exp0 [8];
  logic [1:0] exp1 [4];
  logic [1:0] exp2 [4];

  initial begin
    n_vec  = 0;
    n_err  = 0;
    fs_cnt = 0;
    exp0 = '{2'd1, 2'd0, 2'd1, 2'd1, 2'd1, 2'd0, 2'd1, 2'd1};
    exp1 = '{2'b10, 2'b11, 2'b10, 2'b11};
    exp2 = '{2'b11, 2'b10, 2'b11, 2'b10};

    // Reset, then release.
    step(1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b1, 8'hA5);
    step(1'b1, 1'b1, 1'b0, 8'h00);

    // Single word 0xBB against fixed beat sequences.
    step(1'b1, 1'b1, 1'b1, 8'hBB);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 1'b0, 8'h00);
      obs0[i] = 2'(dout0);
      if (i < 4) begin
        obs1[i] = dout1;
        obs2[i] = dout2;
      end
    end
    for (int i = 0; i < 8; i++) check_eq($sformatf("bb_lane1_beat%0d", i), 64'(obs0[i]),
                                         64'(exp0[i]));
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("bb_lane2_msb_beat%0d", i), 64'(obs1[i]), 64'(exp1[i]));
      check_eq($sformatf("bb_lane2_lsb_beat%0d", i), 64'(obs2[i]), 64'(exp2[i]));
    end
`ifdef SER_GEN_PARITY_EN
    step(1'b1, 1'b1, 1'b0, 8'h00);
    check_eq("parity_bb", 64'(dout0), 64'd0);
    drain();
    step(1'b1, 1'b1, 1'b1, 8'h01);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 1'b0, 8'h00);
    check_eq("parity_01", 64'(dout0), 64'd1);
`endif
    drain();

    // Back-to-back: 0xBB then 0x0F with valid held until accepted.
    fs_cnt = 0;
    step(1'b1, 1'b1, 1'b1, 8'hBB);
    m_acc0 = 1'b0;
    for (int i = 0; i < 20 && !m_acc0; i++) step(1'b1, 1'b1, 1'b1, 8'h0F);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, 8'h00);
    check_eq("b2b_frame_count", 64'(fs_cnt), 64'd2);

    // Stall for 3 cycles after beat 3.
    step(1'b1, 1'b1, 1'b1, 8'hBB);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 8'h00);
      check_eq($sformatf("stall_hold%0d", i), 64'(dout0), 64'd1);
    end
    step(1'b1, 1'b1, 1'b0, 8'h00);
    check_eq("stall_resume_beat4", 64'(dout0), 64'd1);
    step(1'b1, 1'b1, 1'b0, 8'h00);
    check_eq("stall_resume_beat5", 64'(dout0), 64'd0);
    drain();

    // Reset mid-word at beat 5.
    step(1'b1, 1'b1, 1'b1, 8'hBB);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    check_eq("midreset_dout", 64'(dout0), 64'd0);
    check_eq("midreset_busy", 64'(busy0), 64'd0);
    check_eq("midreset_ready", 64'(rdy0), 64'd0);
    step(1'b1, 1'b1, 1'b0, 8'h00);
    check_eq("release_ready", 64'(rdy0), 64'd1);
    check_eq("release_idle_lsb", 64'(dout2), 64'd3);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 59) != 0), ($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ser_gen.md
SER_GEN -- requirements
Module: ser_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 8: parallel word width in bits; legal values are 2..64.
REQ-002 SHALL have parameter LANES, default 1: serial lanes driven per beat; DATA_W must be divisible by LANES, elaboration error otherwise.
REQ-003 SHALL have parameter MSB_FIRST, default 1: 1 sends the most-significant slice first, 0 sends the least-significant slice first.
REQ-004 SHALL have parameter IDLE_BIT, default 0: level driven on every lane when no word is being sent.
REQ-005 SHALL have port clock_160, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-007 SHALL have port enable, input, 1 bit: high lets the shifter advance; low stalls it.
REQ-008 SHALL have port data_in, input, DATA_W bits: parallel word.
REQ-009 SHALL have port data_valid, input, 1 bit: data_in holds a valid word.
REQ-010 SHALL have port data_ready, output, 1 bit: the block can accept a word this cycle.
REQ-011 SHALL have port data_out, output, LANES bits: serial beat, lane 0 = bit 0.
REQ-012 SHALL have port frame_start, output, 1 bit: high during the first beat of each word.
REQ-013 SHALL have port busy, output, 1 bit: the shifter or the holding register is occupied.

Function
REQ-014 SHALL transfer a word on a rising edge where data_valid=1 and data_ready=1.
REQ-015 SHALL send each word as B = DATA_W/LANES beats, one beat per enabled cycle; beat i carries slice i in the MSB_FIRST order.
REQ-016 SHALL buffer two words: a shift register plus one holding register; data_ready = NOT holding_full, with no same-cycle bypass.
REQ-017 SHALL use states IDLE and SHIFT.
  - IDLE -> SHIFT when a word is available and enable=1.
  - SHIFT -> IDLE after the last beat if no word is held.
  - SHIFT -> SHIFT after the last beat if a word is held.
REQ-018 SHALL, for a word accepted at edge k while IDLE with enable=1, drive its first beat on data_out from edge k+1 (latency 1).
REQ-019 SHALL send back-to-back words with no gap: the held word's first beat directly follows the previous word's last beat, with frame_start=1 on that beat.
REQ-020 SHALL, with enable=0:
  - freeze the beat counter;
  - hold data_out at its current value and force frame_start=0;
  - still accept a word into an empty holding register.
REQ-021 SHALL drive data_out to IDLE_BIT on all lanes, and frame_start=0, whenever the state is IDLE.
REQ-022 SHALL keep the beat counter width at clog2(B+1) and wrap it to 0 after the last beat; no other overflow is allowed.
REQ-023 SHALL ignore data_in while data_ready=0; the held word must not be overwritten.

Reset
REQ-024 SHALL, on a rising edge with reset=0, set the state to IDLE, the counter to 0, and both buffers to empty; this holds even mid-word.
REQ-025 SHALL drive these values while in reset: data_out = IDLE_BIT on all lanes, frame_start=0, busy=0, data_ready=0.
REQ-026 SHALL raise data_ready on the first edge after reset returns high; a partially sent word is discarded.

Configuration
REQ-027 SHALL, when SER_GEN_PARITY_EN is defined, append one extra beat per word: lane 0 = even parity (XOR of all DATA_W bits), other lanes = IDLE_BIT, so B becomes DATA_W/LANES+1.
REQ-028 SHALL, when SER_GEN_PARITY_EN is undefined, send no parity beat and contain no parity logic.

Structure
REQ-029 SHALL place in shared package ser_pkg:
  - the state enum (IDLE, SHIFT);
  - a beats-per-word constant function;
  - the parity-beat constant derived from the macro.
REQ-030 SHALL put the holding register and its full flag and handshake in one sub-module, ser_hold_reg; shift and control logic stays in ser_gen.

Verification
REQ-031 SHALL check: DATA_W=8, LANES=1, MSB_FIRST=1, word 0xBB -> beats 1,0,1,1,1,0,1,1; frame_start on beat 0 only; then IDLE_BIT.
REQ-032 SHALL check: LANES=2, word 0xBB -> beats 2'b10, 2'b11, 2'b10, 2'b11; with MSB_FIRST=0 -> 2'b11, 2'b10, 2'b11, 2'b10.
REQ-033 SHALL check back-to-back: 0xBB then 0x0F with data_valid held high -> 16 contiguous beats; frame_start at beats 0 and 8; data_ready low while the holding register is full.
REQ-034 SHALL check enable low for 3 cycles after beat 3 of 0xBB -> data_out holds for 3 cycles, then the sequence resumes at beat 4 with no beat lost.
REQ-035 SHALL check reset=0 at beat 5 -> next edge data_out=IDLE_BIT and busy=0; data_ready=1 one edge after release.
REQ-036 SHALL check with SER_GEN_PARITY_EN: 0xBB -> ninth beat 0; 0x01 -> ninth beat 1.
